// File: rtl/macc_dot_sequencer.sv
// Operand sequencer and result FIFO around a free-running unsigned multiply-accumulate DSP.
// Build macro MACC_DOT_SAT_EN: saturate m_z to OUT_W bits and flag m_sat (default: truncate, m_sat=0).
module macc_dot_sequencer #(
   parameter int DSP_LAT    = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int OUT_W      = 32,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             lreset,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [19:0]      s_a,
   input  logic [17:0]      s_b,
   input  logic             s_last,
   output logic [19:0]      dsp_a,
   output logic [17:0]      dsp_b,
   output logic             dsp_load_acc,
   input  logic [37:0]      dsp_z,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [OUT_W-1:0] m_z,
   output logic [CNT_W-1:0] m_terms,
   output logic             m_sat
);

   localparam int PIPE_N = DSP_LAT + 1;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int CW     = $clog2(FIFO_DEPTH + PIPE_N + 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ACCUM = 1'b1;

   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

`ifdef MACC_DOT_SAT_EN
   // Returns {sat, value}; anything at or above 2**OUT_W clamps to all-ones.
   function automatic logic [OUT_W:0] shape_z(input logic [37:0] z);
      if ((z >> OUT_W) != 38'd0)
         return {1'b1, {OUT_W{1'b1}}};
      return {1'b0, z[OUT_W-1:0]};
   endfunction
`else
   function automatic logic [OUT_W:0] shape_z(input logic [37:0] z);
      return {1'b0, z[OUT_W-1:0]};
   endfunction

   if (OUT_W < 38) begin : g_trunc
      logic w_unused_hi;
      assign w_unused_hi = ^dsp_z[37:OUT_W];
   end
`endif

   logic [0:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [19:0]       r_dsp_a;
   logic [17:0]       r_dsp_b;
   logic              r_dsp_load;
   logic [PIPE_N-1:0] r_pipe_last;
   logic [CNT_W-1:0]  r_pipe_cnt [PIPE_N];
   logic [OUT_W-1:0]  r_mem_z [FIFO_DEPTH];
   logic [CNT_W-1:0]  r_mem_terms [FIFO_DEPTH];
   logic              r_mem_sat [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_fifo_cnt;

   logic              w_accept;
   logic              w_push;
   logic              w_pop;
   logic [CNT_W-1:0]  w_cnt_next;
   logic [CW-1:0]     w_inflight;
   logic [CW-1:0]     w_used;
   logic [OUT_W:0]    w_shaped;

   // Credits cover both queued results and frame ends still travelling down the DSP pipe.
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < PIPE_N; i++)
         w_inflight = w_inflight + CW'(r_pipe_last[i]);
   end

   assign w_used     = CW'(r_fifo_cnt) + w_inflight;
   assign s_ready    = (w_used < CW'(FIFO_DEPTH));
   assign w_accept   = s_valid & s_ready;
   assign w_cnt_next = (r_state == ST_IDLE) ? CNT_W'(1) : cnt_inc(r_cnt);

   always_ff @(posedge clk or negedge lreset) begin
      if (!lreset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_state <= s_last ? ST_IDLE : ST_ACCUM;
         r_cnt   <= w_cnt_next;
      end
   end

   // Idle cycles feed 0*0 with load_acc=1 so the DSP accumulator simply holds.
   always_ff @(posedge clk or negedge lreset) begin
      if (!lreset) begin
         r_dsp_a    <= '0;
         r_dsp_b    <= '0;
         r_dsp_load <= 1'b0;
      end else if (w_accept) begin
         r_dsp_a    <= s_a;
         r_dsp_b    <= s_b;
         r_dsp_load <= (r_state == ST_ACCUM);
      end else begin
         r_dsp_a    <= '0;
         r_dsp_b    <= '0;
         r_dsp_load <= 1'b1;
      end
   end

   assign dsp_a        = r_dsp_a;
   assign dsp_b        = r_dsp_b;
   assign dsp_load_acc = r_dsp_load;

   always_ff @(posedge clk or negedge lreset) begin
      if (!lreset) begin
         r_pipe_last <= '0;
      end else begin
         r_pipe_last[0] <= w_accept & s_last;
         for (int i = 1; i < PIPE_N; i++)
            r_pipe_last[i] <= r_pipe_last[i-1];
      end
   end

   always_ff @(posedge clk) begin
      r_pipe_cnt[0] <= w_cnt_next;
      for (int i = 1; i < PIPE_N; i++)
         r_pipe_cnt[i] <= r_pipe_cnt[i-1];
   end

   // A frame end leaving the pipe lines up with dsp_z holding that frame's full sum.
   assign w_push   = r_pipe_last[PIPE_N-1];
   assign w_pop    = m_valid & m_ready;
   assign w_shaped = shape_z(dsp_z);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_z[r_wr_ptr]     <= w_shaped[OUT_W-1:0];
         r_mem_sat[r_wr_ptr]   <= w_shaped[OUT_W];
         r_mem_terms[r_wr_ptr] <= r_pipe_cnt[PIPE_N-1];
      end
   end

   always_ff @(posedge clk or negedge lreset) begin
      if (!lreset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + (AW+1)'(1);
            2'b01:   r_fifo_cnt <= r_fifo_cnt - (AW+1)'(1);
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   assign m_valid = (r_fifo_cnt != '0);
   assign m_z     = r_mem_z[r_rd_ptr];
   assign m_terms = r_mem_terms[r_rd_ptr];
   assign m_sat   = r_mem_sat[r_rd_ptr];

endmodule

// File: tb/tb_macc_dot_sequencer.sv
// Directed bench for macc_dot_sequencer with a behavioural registered-output multiply-accumulate DSP.
module tb_macc_dot_sequencer;

   localparam int OUT_W = 32;
   localparam int CNT_W = 16;

   logic             clk;
   logic             lreset;
   logic             s_valid;
   logic             s_ready;
   logic [19:0]      s_a;
   logic [17:0]      s_b;
   logic             s_last;
   logic [19:0]      dsp_a;
   logic [17:0]      dsp_b;
   logic             dsp_load_acc;
   logic [37:0]      dsp_z;
   logic             m_valid;
   logic             m_ready;
   logic [OUT_W-1:0] m_z;
   logic [CNT_W-1:0] m_terms;
   logic             m_sat;

   int n_checks;
   int n_pass;

   macc_dot_sequencer #(
      .DSP_LAT(1), .FIFO_DEPTH(4), .OUT_W(OUT_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .lreset(lreset),
      .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_load_acc(dsp_load_acc), .dsp_z(dsp_z),
      .m_valid(m_valid), .m_ready(m_ready), .m_z(m_z), .m_terms(m_terms), .m_sat(m_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DSP model: accumulator register, z = load_acc ? z + a*b : a*b
   always @(posedge clk) begin
      if (dsp_load_acc)
         dsp_z <= dsp_z + 38'(dsp_a) * 38'(dsp_b);
      else
         dsp_z <= 38'(dsp_a) * 38'(dsp_b);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_mvalid(input string tag);
      int n;
      n = 0;
      while (m_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (m_valid !== 1'b1) begin
         n_checks++;
         $display("FAIL %s_timeout: m_valid got %b want 1", tag, m_valid);
      end
   endtask

   task automatic test_reset();
      lreset = 1'b0;
      repeat (3) tick();
      n_checks++; if (dsp_a !== 20'd0) $display("FAIL rst_dsp_a: got %0d want 0", dsp_a); else n_pass++;
      n_checks++; if (dsp_b !== 18'd0) $display("FAIL rst_dsp_b: got %0d want 0", dsp_b); else n_pass++;
      n_checks++; if (dsp_load_acc !== 1'b0) $display("FAIL rst_load: got %b want 0", dsp_load_acc); else n_pass++;
      n_checks++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b want 0", m_valid); else n_pass++;
      n_checks++; if (s_ready !== 1'b1) $display("FAIL rst_s_ready: got %b want 1", s_ready); else n_pass++;
      lreset = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      m_ready = 1'b1;
      s_valid = 1'b1; s_a = 20'd2; s_b = 18'd3; s_last = 1'b0;
      n_checks++; if (s_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", s_ready); else n_pass++;
      tick();
      n_checks++; if (dsp_a !== 20'd2) $display("FAIL b2b_dsp_a0: got %0d want 2", dsp_a); else n_pass++;
      n_checks++; if (dsp_load_acc !== 1'b0) $display("FAIL b2b_load0: got %b want 0", dsp_load_acc); else n_pass++;
      s_a = 20'd4; s_b = 18'd5;
      tick();
      n_checks++; if (dsp_b !== 18'd5) $display("FAIL b2b_dsp_b1: got %0d want 5", dsp_b); else n_pass++;
      n_checks++; if (dsp_load_acc !== 1'b1) $display("FAIL b2b_load1: got %b want 1", dsp_load_acc); else n_pass++;
      s_a = 20'd6; s_b = 18'd7; s_last = 1'b1;
      tick();
      s_valid = 1'b0; s_last = 1'b0; s_a = '0; s_b = '0;
      n_checks++; if (m_valid !== 1'b0) $display("FAIL b2b_lat1: m_valid got %b want 0", m_valid); else n_pass++;
      tick();
      n_checks++; if (m_valid !== 1'b0) $display("FAIL b2b_lat2: m_valid got %b want 0", m_valid); else n_pass++;
      tick();
      n_checks++; if (m_valid !== 1'b1) $display("FAIL b2b_lat3: m_valid got %b want 1", m_valid); else n_pass++;
      n_checks++; if (m_z !== 32'd68) $display("FAIL b2b_z: got %0d want 68", m_z); else n_pass++;
      n_checks++; if (m_terms !== 16'd3) $display("FAIL b2b_terms: got %0d want 3", m_terms); else n_pass++;
      n_checks++; if (m_sat !== 1'b0) $display("FAIL b2b_sat: got %b want 0", m_sat); else n_pass++;
      tick();
      n_checks++; if (m_valid !== 1'b0) $display("FAIL b2b_pop: m_valid got %b want 0", m_valid); else n_pass++;
   endtask

   task automatic test_gaps();
      m_ready = 1'b1;
      s_valid = 1'b1; s_a = 20'd2; s_b = 18'd3; s_last = 1'b0;
      tick();
      s_valid = 1'b0;
      tick();
      n_checks++; if (dsp_a !== 20'd0 || dsp_b !== 18'd0) $display("FAIL gap_zero: a/b got %0d/%0d want 0/0", dsp_a, dsp_b); else n_pass++;
      n_checks++; if (dsp_load_acc !== 1'b1) $display("FAIL gap_hold: load got %b want 1", dsp_load_acc); else n_pass++;
      tick();
      s_valid = 1'b1; s_a = 20'd4; s_b = 18'd5;
      tick();
      s_valid = 1'b0;
      repeat (2) tick();
      s_valid = 1'b1; s_a = 20'd6; s_b = 18'd7; s_last = 1'b1;
      tick();
      s_valid = 1'b0; s_last = 1'b0;
      wait_mvalid("gap");
      n_checks++; if (m_z !== 32'd68) $display("FAIL gap_z: got %0d want 68", m_z); else n_pass++;
      n_checks++; if (m_terms !== 16'd3) $display("FAIL gap_terms: got %0d want 3", m_terms); else n_pass++;
      tick();
   endtask

   task automatic test_wide();
      logic [31:0] exp_z;
      logic        exp_sat;
`ifdef MACC_DOT_SAT_EN
      exp_z = 32'hFFFF_FFFF; exp_sat = 1'b1;
`else
      exp_z = 32'hFFEC_0001; exp_sat = 1'b0;
`endif
      m_ready = 1'b1;
      s_valid = 1'b1; s_a = 20'd1048575; s_b = 18'd262143; s_last = 1'b1;
      tick();
      s_valid = 1'b0; s_last = 1'b0;
      wait_mvalid("wide");
      n_checks++; if (m_z !== exp_z) $display("FAIL wide_z: got %0h want %0h", m_z, exp_z); else n_pass++;
      n_checks++; if (m_sat !== exp_sat) $display("FAIL wide_sat: got %b want %b", m_sat, exp_sat); else n_pass++;
      n_checks++; if (m_terms !== 16'd1) $display("FAIL wide_terms: got %0d want 1", m_terms); else n_pass++;
      tick();
   endtask

   task automatic test_credit();
      int  k;
      int  got;
      bit  was_ready;
      m_ready = 1'b0;
      k = 1;
      s_b = 18'd1; s_last = 1'b1;
      for (int c = 0; c < 6; c++) begin
         s_valid = 1'b1; s_a = 20'(k);
         was_ready = s_ready;
         tick();
         if (was_ready) k++;
      end
      n_checks++; if (k - 1 != 4) $display("FAIL credit_accepted: got %0d want 4", k - 1); else n_pass++;
      n_checks++; if (s_ready !== 1'b0) $display("FAIL credit_stall: s_ready got %b want 0", s_ready); else n_pass++;
      repeat (3) tick();
      n_checks++; if (s_ready !== 1'b0) $display("FAIL credit_full: s_ready got %b want 0", s_ready); else n_pass++;
      n_checks++; if (m_z !== 32'd1) $display("FAIL credit_head: m_z got %0d want 1", m_z); else n_pass++;
      m_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 40 && got < 6; c++) begin
         was_ready = s_valid && s_ready;
         if (m_valid === 1'b1) begin
            n_checks++;
            if (m_z !== 32'(got + 1)) $display("FAIL credit_order%0d: m_z got %0d want %0d", got, m_z, got + 1);
            else n_pass++;
            got++;
         end
         tick();
         if (was_ready) begin
            k++;
            if (k > 6) s_valid = 1'b0;
            else s_a = 20'(k);
         end
      end
      s_valid = 1'b0; s_last = 1'b0;
      n_checks++; if (got != 6) $display("FAIL credit_delivered: got %0d want 6", got); else n_pass++;
      n_checks++; if (m_valid !== 1'b0) $display("FAIL credit_empty: m_valid got %b want 0", m_valid); else n_pass++;
   endtask

   task automatic test_mid_reset();
      m_ready = 1'b0;
      s_valid = 1'b1; s_a = 20'd5; s_b = 18'd5; s_last = 1'b1;
      tick();
      s_a = 20'd7; s_b = 18'd7; s_last = 1'b0;
      tick();
      s_a = 20'd8; s_b = 18'd8;
      tick();
      s_valid = 1'b0;
      tick();
      #1 lreset = 1'b0;
      #1;
      n_checks++; if (dsp_a !== 20'd0 || dsp_b !== 18'd0) $display("FAIL mrst_ab: got %0d/%0d want 0/0", dsp_a, dsp_b); else n_pass++;
      n_checks++; if (dsp_load_acc !== 1'b0) $display("FAIL mrst_load: got %b want 0", dsp_load_acc); else n_pass++;
      n_checks++; if (m_valid !== 1'b0) $display("FAIL mrst_m_valid: got %b want 0", m_valid); else n_pass++;
      n_checks++; if (s_ready !== 1'b1) $display("FAIL mrst_s_ready: got %b want 1", s_ready); else n_pass++;
      tick();
      lreset = 1'b1;
      repeat (3) tick();
      n_checks++; if (m_valid !== 1'b0) $display("FAIL mrst_stale: m_valid got %b want 0", m_valid); else n_pass++;
      m_ready = 1'b1;
      s_valid = 1'b1; s_a = 20'd3; s_b = 18'd3; s_last = 1'b1;
      tick();
      s_valid = 1'b0; s_last = 1'b0;
      wait_mvalid("mrst");
      n_checks++; if (m_z !== 32'd9) $display("FAIL mrst_z: got %0d want 9", m_z); else n_pass++;
      n_checks++; if (m_terms !== 16'd1) $display("FAIL mrst_terms: got %0d want 1", m_terms); else n_pass++;
      tick();
   endtask

   task automatic test_full_rw();
      m_ready = 1'b0;
      s_b = 18'd1; s_last = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_a = 20'(10 * (i + 1));
         tick();
      end
      s_valid = 1'b0;
      repeat (3) tick();
      n_checks++; if (s_ready !== 1'b0) $display("FAIL frw_full: s_ready got %b want 0", s_ready); else n_pass++;
      n_checks++; if (m_z !== 32'd10) $display("FAIL frw_head: m_z got %0d want 10", m_z); else n_pass++;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      n_checks++; if (s_ready !== 1'b1) $display("FAIL frw_credit: s_ready got %b want 1", s_ready); else n_pass++;
      s_valid = 1'b1; s_a = 20'd50;
      tick();
      s_valid = 1'b0; s_last = 1'b0;
      n_checks++; if (s_ready !== 1'b0) $display("FAIL frw_inflight: s_ready got %b want 0", s_ready); else n_pass++;
      tick();
      n_checks++; if (m_z !== 32'd20) $display("FAIL frw_hold: m_z got %0d want 20", m_z); else n_pass++;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      n_checks++; if (m_z !== 32'd30) $display("FAIL frw_rw: m_z got %0d want 30", m_z); else n_pass++;
      tick();
      n_checks++; if (m_z !== 32'd30) $display("FAIL frw_stable: m_z got %0d want 30", m_z); else n_pass++;
      m_ready = 1'b1;
      tick();
      n_checks++; if (m_z !== 32'd40) $display("FAIL frw_d40: m_z got %0d want 40", m_z); else n_pass++;
      tick();
      n_checks++; if (m_z !== 32'd50) $display("FAIL frw_d50: m_z got %0d want 50", m_z); else n_pass++;
      tick();
      n_checks++; if (m_valid !== 1'b0) $display("FAIL frw_empty: m_valid got %b want 0", m_valid); else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      lreset   = 1'b0;
      s_valid  = 1'b0;
      s_a      = '0;
      s_b      = '0;
      s_last   = 1'b0;
      m_ready  = 1'b0;
      test_reset();
      test_back_to_back();
      test_gaps();
      test_wide();
      test_credit();
      test_mid_reset();
      test_full_rw();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
